// File: rtl/car_motion_ctrl.sv
// Elevator car motion controller: IDLE/MOVE/DOOR sequencer that steps a one-hot
// floor position on a move timer and holds the door for a dwell period.
module car_motion_ctrl #(
  parameter int MOVE_TICKS = 64,
  parameter int DOOR_TICKS = 96
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ud_mode,
  input  logic [3:0] eff_req,
  input  logic       call_here,
  input  logic       door_hold,
  input  logic       door_close,
  output logic [3:0] position,
  output logic [1:0] floor_bin,
  output logic       moving,
  output logic [1:0] dir,
  output logic       door_open,
  output logic       arrive
);
  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_t;

  localparam logic [7:0] MOVE_LOAD = 8'(MOVE_TICKS - 1);
  localparam logic [7:0] DOOR_LOAD = 8'(DOOR_TICKS - 1);
  localparam logic [1:0] DIR_UP = 2'b01;
  localparam logic [1:0] DIR_DN = 2'b10;

  state_t     state_q, state_d;
  logic [3:0] pos_q, pos_d;
  logic [1:0] dir_q, dir_d;
  logic       moving_q, moving_d;
  logic       door_open_q, door_open_d;
  logic       arrive_q, arrive_d;
  logic [7:0] mcnt_q, mcnt_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic [3:0] next_pos;
  logic       stop_here;

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    moving_d    = moving_q;
    door_open_d = door_open_q;
    arrive_d    = 1'b0;
    mcnt_d      = mcnt_q;
    dcnt_d      = dcnt_q;
    next_pos    = (dir_q == DIR_UP) ? {pos_q[2:0], 1'b0} : {1'b0, pos_q[3:1]};
    // A terminal floor always stops, so position can never shift off the end.
    stop_here   = (|(eff_req & next_pos)) || (ud_mode != dir_q) ||
                  (dir_q == DIR_UP && next_pos[3]) || (dir_q == DIR_DN && next_pos[0]);
    case (state_q)
      S_IDLE: begin
        if (call_here) begin
          state_d     = S_DOOR;
          door_open_d = 1'b1;
          dcnt_d      = DOOR_LOAD;
        end else if ((ud_mode == DIR_UP && !pos_q[3]) || (ud_mode == DIR_DN && !pos_q[0])) begin
          state_d  = S_MOVE;
          moving_d = 1'b1;
          dir_d    = ud_mode;
          mcnt_d   = MOVE_LOAD;
        end
      end
      S_MOVE: begin
        if (mcnt_q == 8'd0) begin
          pos_d    = next_pos;
          arrive_d = 1'b1;
          if (stop_here) begin
            state_d     = S_DOOR;
            moving_d    = 1'b0;
            dir_d       = 2'b00;
            door_open_d = 1'b1;
            dcnt_d      = DOOR_LOAD;
          end else begin
            mcnt_d = MOVE_LOAD;
          end
        end else begin
          mcnt_d = mcnt_q - 8'd1;
        end
      end
      S_DOOR: begin
        if (door_hold) begin
          dcnt_d = DOOR_LOAD;
        end else if (door_close || dcnt_q == 8'd0) begin
          state_d     = S_IDLE;
          door_open_d = 1'b0;
          dcnt_d      = 8'd0;
        end else begin
          dcnt_d = dcnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pos_q       <= 4'b0001;
      dir_q       <= 2'b00;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
      arrive_q    <= 1'b0;
      mcnt_q      <= 8'd0;
      dcnt_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      moving_q    <= moving_d;
      door_open_q <= door_open_d;
      arrive_q    <= arrive_d;
      mcnt_q      <= mcnt_d;
      dcnt_q      <= dcnt_d;
    end
  end

  always_comb begin
    floor_bin = 2'd0;
    case (pos_q)
      4'b0010: floor_bin = 2'd1;
      4'b0100: floor_bin = 2'd2;
      4'b1000: floor_bin = 2'd3;
      default: floor_bin = 2'd0;
    endcase
  end

  assign position  = pos_q;
  assign moving    = moving_q;
  assign dir       = dir_q;
  assign door_open = door_open_q;
  assign arrive    = arrive_q;
endmodule

// File: tb/tb_car_motion_ctrl.sv
// Directed bench for car_motion_ctrl: a floor/elapsed-time model is checked every
// cycle, plus hand-computed spot checks on the reference scenarios.
module tb_car_motion_ctrl;
  localparam int MT = 4;
  localparam int DT = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] ud_mode = 2'b00;
  logic [3:0] eff_req = 4'b0000;
  logic call_here = 1'b0, door_hold = 1'b0, door_close = 1'b0;
  logic [3:0] position;
  logic [1:0] floor_bin, dir;
  logic moving, door_open, arrive;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  car_motion_ctrl #(.MOVE_TICKS(MT), .DOOR_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .ud_mode(ud_mode), .eff_req(eff_req), .call_here(call_here),
    .door_hold(door_hold), .door_close(door_close), .position(position),
    .floor_bin(floor_bin), .moving(moving), .dir(dir), .door_open(door_open), .arrive(arrive)
  );

  always #5 clk = ~clk;

  // Model: mode 0 idle / 1 travelling / 2 door open; floor is an index 0..3.
  int m_mode = 0, m_floor = 0, m_dir = 0, m_elapsed = 0;
  bit m_arrive = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_floor = 0; m_dir = 0; m_elapsed = 0; m_arrive = 0;
    end else begin
      m_arrive = 0;
      if (m_mode == 0) begin
        if (call_here) begin
          m_mode = 2; m_elapsed = 0;
        end else if (ud_mode == 2'b01 && m_floor < 3) begin
          m_mode = 1; m_dir = 1; m_elapsed = 0;
        end else if (ud_mode == 2'b10 && m_floor > 0) begin
          m_mode = 1; m_dir = 2; m_elapsed = 0;
        end
      end else if (m_mode == 1) begin
        m_elapsed++;
        if (m_elapsed == MT) begin
          m_floor = (m_dir == 1) ? m_floor + 1 : m_floor - 1;
          m_arrive = 1;
          m_elapsed = 0;
          if (eff_req[m_floor] || int'(ud_mode) != m_dir || m_floor == 0 || m_floor == 3) begin
            m_mode = 2; m_dir = 0;
          end
        end
      end else begin
        if (door_hold) m_elapsed = 0;
        else if (door_close) m_mode = 0;
        else begin
          m_elapsed++;
          if (m_elapsed == DT) m_mode = 0;
        end
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("position", int'(position), 1 << m_floor);
      chk("floor_bin", int'(floor_bin), m_floor);
      chk("moving", int'(moving), int'(m_mode == 1));
      chk("dir", int'(dir), m_dir);
      chk("door_open", int'(door_open), int'(m_mode == 2));
      chk("arrive", int'(arrive), int'(m_arrive));
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    checking = 1'b1;
    chk("rst_position", int'(position), 1);
    chk("rst_floor_bin", int'(floor_bin), 0);
    chk("rst_moving", int'(moving), 0);
    chk("rst_dir", int'(dir), 0);
    chk("rst_door", int'(door_open), 0);
    chk("rst_arrive", int'(arrive), 0);

    // Up from floor 1, pass floor 2, stop at requested floor 3.
    ud_mode = 2'b01; eff_req = 4'b0100;
    step(1);
    chk("up_moving", int'(moving), 1);
    chk("up_dir", int'(dir), 1);
    step(3);
    chk("up_pre_arrive", int'(arrive), 0);
    step(1);
    chk("arr_f2", int'(arrive), 1);
    chk("arr_f2_pos", int'(position), 2);
    chk("arr_f2_moving", int'(moving), 1);
    step(4);
    chk("arr_f3", int'(arrive), 1);
    chk("arr_f3_pos", int'(position), 4);
    chk("arr_f3_door", int'(door_open), 1);
    chk("arr_f3_dir", int'(dir), 0);
    ud_mode = 2'b00; eff_req = 4'b0000;

    // Dwell with a 3-cycle hold, then 6 more cycles open.
    step(2);
    door_hold = 1'b1;
    step(3);
    door_hold = 1'b0;
    step(5);
    chk("dwell_still_open", int'(door_open), 1);
    step(1);
    chk("dwell_closed", int'(door_open), 0);

    // Door close, and hold overriding close.
    call_here = 1'b1;
    step(1);
    call_here = 1'b0;
    chk("call_door", int'(door_open), 1);
    door_hold = 1'b1; door_close = 1'b1;
    step(1);
    chk("hold_beats_close", int'(door_open), 1);
    door_hold = 1'b0;
    step(1);
    chk("close_now", int'(door_open), 0);
    door_close = 1'b0;

    // Floor 3 to terminal floor 4 with no request.
    ud_mode = 2'b01;
    step(5);
    chk("term_f4", int'(position), 8);
    chk("term_f4_door", int'(door_open), 1);
    ud_mode = 2'b00; door_close = 1'b1;
    step(1);
    door_close = 1'b0;

    // Up at floor 4 ignored; then down to floor 1.
    ud_mode = 2'b01;
    step(3);
    chk("f4_up_ignored", int'(moving), 0);
    chk("f4_up_pos", int'(position), 8);
    ud_mode = 2'b10; eff_req = 4'b0001;
    step(1);
    chk("down_dir", int'(dir), 2);
    step(12);
    chk("down_f1", int'(position), 1);
    chk("down_f1_door", int'(door_open), 1);
    ud_mode = 2'b00; eff_req = 4'b0000; door_close = 1'b1;
    step(1);
    door_close = 1'b0;

    // call_here beats ud_mode in IDLE.
    ud_mode = 2'b01; call_here = 1'b1;
    step(1);
    chk("call_pri_door", int'(door_open), 1);
    chk("call_pri_pos", int'(position), 1);
    chk("call_pri_moving", int'(moving), 0);
    ud_mode = 2'b00; call_here = 1'b0; door_close = 1'b1;
    step(1);
    door_close = 1'b0;

    // Go to floor 2, then reset two cycles into the next move.
    ud_mode = 2'b01; eff_req = 4'b0010;
    step(5);
    chk("f2_stop", int'(position), 2);
    ud_mode = 2'b00; eff_req = 4'b0000; door_close = 1'b1;
    step(1);
    door_close = 1'b0; ud_mode = 2'b01;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0; ud_mode = 2'b00;
    chk("rst_mid_pos", int'(position), 1);
    chk("rst_mid_moving", int'(moving), 0);
    chk("rst_mid_door", int'(door_open), 0);
    chk("rst_mid_arrive", int'(arrive), 0);
    step(4);
    chk("rst_no_arrive", int'(arrive), 0);

    // Mode 11 behaves like stop.
    ud_mode = 2'b11;
    step(2);
    chk("mode11_idle", int'(moving), 0);
    ud_mode = 2'b00;
    step(1);

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
